// File: rtl/int_subtractor_serial.sv
// Digit-serial integer subtractor: diff = data_a - data_b - borrow_in, LSB digit first.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output.
module int_subtractor_serial #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  borrow_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
    output logic                  overflow,
`endif
    output logic                  borrow_out
);

    localparam int N  = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [DATA_WIDTH-1:0]   res_reg;
    logic                    borrow_reg;
    logic [CW-1:0]           cnt;
    logic [DIGIT_WIDTH:0]    digit_diff;
    logic [DATA_WIDTH-1:0]   res_shift;

    // Operands shift right one digit per cycle so the active digit is always at bit 0;
    // result digits enter from the top and are aligned after the last digit.
    always_comb begin
        digit_diff = {1'b0, a_reg[DIGIT_WIDTH-1:0]}
                   - {1'b0, b_reg[DIGIT_WIDTH-1:0]}
                   - (DIGIT_WIDTH+1)'(borrow_reg);
        res_shift  = (res_reg >> DIGIT_WIDTH)
                   | (DATA_WIDTH'(digit_diff[DIGIT_WIDTH-1:0]) << (DATA_WIDTH - DIGIT_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= data_a;
                        b_reg      <= data_b;
                        borrow_reg <= borrow_in;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    a_reg      <= a_reg >> DIGIT_WIDTH;
                    b_reg      <= b_reg >> DIGIT_WIDTH;
                    res_reg    <= res_shift;
                    borrow_reg <= digit_diff[DIGIT_WIDTH];
                    cnt        <= cnt + CW'(1);
                    if (cnt == LAST_DIGIT) begin
                        // Outputs only change here, so they stay put through DONE and IDLE.
                        diff       <= res_shift;
                        borrow_out <= digit_diff[DIGIT_WIDTH];
`ifdef SUB_OVERFLOW_EN
                        overflow   <= (a_reg[DIGIT_WIDTH-1] != b_reg[DIGIT_WIDTH-1]) &&
                                      (digit_diff[DIGIT_WIDTH-1] != a_reg[DIGIT_WIDTH-1]);
`endif
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_int_subtractor_serial.sv
// Self-checking bench for int_subtractor_serial (32-bit operands, 8-bit digits).
// Expected results come from a full-width reference model queued at accept time.
module tb_int_subtractor_serial;

    localparam int W   = 32;
    localparam int DIG = 8;
    localparam int N   = W / DIG;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    int_subtractor_serial #(.DATA_WIDTH(W), .DIGIT_WIDTH(DIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef SUB_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Waits for in_ready, drives one operation for a single accept edge and queues the model result
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int          guard;
        logic [W:0]  full;
        exp_t        e;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        data_a    = a;
        data_b    = b;
        borrow_in = bin;
        in_valid  = 1'b1;
        full = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        e.d  = full[W-1:0];
        e.b  = full[W];
        e.o  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the result, optionally stalls the consumer, then compares against the queue head
    task automatic collectResult(input int hold, input bit check_latency);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
            return;
        end
        if (check_latency) checkOutput("latency", 64'(cycles), 64'(N));
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput("diff", 64'(diff), 64'(e.d));
        checkOutput("borrow_out", 64'(borrow_out), 64'(e.b));
`ifdef SUB_OVERFLOW_EN
        checkOutput("overflow", 64'(overflow), 64'(e.o));
`endif
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = ~in_valid;
            data_a    = $urandom;
            @(posedge clk);
            #1;
            checkOutput("hold_diff", 64'(diff), 64'(e.d));
            checkOutput("hold_borrow", 64'(borrow_out), 64'(e.b));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("consumed_out_valid", 64'(out_valid), 64'd0);
        checkOutput("consumed_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_diff_kept", 64'(diff), 64'(e.d));
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        applyStimulus(a, b, bin);
        collectResult(0, 1'b1);
    endtask

    initial begin
        // Reset values while rst is held high
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_diff", 64'(diff), 64'd0);
        checkOutput("reset_borrow", 64'(borrow_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic, ripple and borrow_in cases");
        runOp(32'h0000_0005, 32'h0000_0003, 1'b0);
        runOp(32'h0000_0000, 32'h0000_0001, 1'b0);
        runOp(32'h1234_5678, 32'h1234_5678, 1'b1);
        runOp(32'h1234_5679, 32'h1234_5678, 1'b1);

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        applyStimulus(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
        collectResult(6, 1'b1);

        // Abort after two digits; nothing from this operation may ever appear
        $display("[TB] reset during BUSY");
        applyStimulus(32'h0F0F_0F0F, 32'h1111_1111, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_diff", 64'(diff), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (N + 2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("after_reset_out_valid", 64'(out_valid), 64'd0);
        runOp(32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);

        $display("[TB] signed overflow cases");
        runOp(32'h8000_0000, 32'h0000_0001, 1'b0);
        runOp(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp(32'h0000_0005, 32'h0000_0003, 1'b0);

        $display("[TB] random operands");
        for (int i = 0; i < 8; i++) begin
            runOp(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends with a summary
    initial begin
        #200000;
        checkOutput("global_timeout", 64'd0, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
